multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control sequencer for the RV32I core variant that shares one ALU and one register-file write port across all execution steps. It takes the opcode held in the instruction register and steps the datapath through fetch, decode, execute, memory and write-back. It also handles the I-cache and D-cache stall handshakes and counts retired instructions. It sits between the instruction register and the datapath muxes, and replaces the single-cycle opcode decoder in this core variant.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous, active-high
- opcode  in  7  instruction register bits [6:0]; stable from DECODE onward
- branch_taken  in  1  ALU compare result; sampled in EXEC of BTYPE only
- icache_stall  in  1  high while I-cache busy
- dcache_stall  in  1  high while D-cache busy
- icache_read  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- dcache_read  out  1  load request
- dcache_write  out  1  store request
- alusrc  out  1  0 = rs2, 1 = immediate
- aluop  out  2  00 R, 01 I, 10 address/compare, 11 jump
- regwrite  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
- pc_we  out  1  PC update enable; marks instruction retirement
- pc_sel  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target (ALU)
- illegal  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  retired-instruction count

## Operation
States are FETCH, DECODE, EXEC, MEM, WB and HALT.

- FETCH:
  - icache_read=1.
  - If icache_stall=0: ir_we=1, go to DECODE.
  - Otherwise stay in FETCH with icache_read held.
- DECODE:
  - Classify the opcode using 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BTYPE, 1101111 JAL, 1100111 JALR.
  - Any other opcode: go to HALT and set illegal.
  - Otherwise go to EXEC.
- EXEC:
  - aluop and alusrc follow the class: R 00/0, I 01/1, LOAD and STORE 10/1, BTYPE 10/0, JAL 11/0, JALR 11/1.
  - R, I, LOAD, STORE: go to MEM for LOAD and STORE, WB for R and I.
  - BTYPE: pc_we=1, pc_sel = branch_taken ? 01 : 00, then FETCH.
  - JAL and JALR: regwrite=1, wb_sel=10, pc_we=1, pc_sel 01 (JAL) or 10 (JALR), then FETCH.
- MEM:
  - aluop=10 and alusrc=1 are held.
  - dcache_read (LOAD) or dcache_write (STORE) is held until dcache_stall=0.
  - On that cycle, LOAD goes to WB.
  - STORE asserts pc_we=1, pc_sel=00, then FETCH.
- WB:
  - regwrite=1, pc_we=1, pc_sel=00.
  - wb_sel is 01 for LOAD, 00 for R and I.
  - Then FETCH.
- HALT:
  - Terminal state; all enables are 0 and illegal=1.
  - Exits only through rst.
- The opcode class is registered at the end of DECODE and used in later states; opcode changes after DECODE are ignored.
- Any output not listed for a state is 0.
- retired increments by 1 on every cycle with pc_we=1 and wraps from all-ones to 0.

## Timing
- Reset:
  - In any cycle with rst=1, every output is 0 and retired=0 in that cycle.
  - On the next edge: state=FETCH, illegal=0, retired=0.
  - rst mid-MEM or mid-FETCH drops the pending cache request immediately; no pc_we or regwrite is issued for the aborted instruction.
- Minimum cycles per instruction with zero stalls:
  - BTYPE, JAL, JALR: 3.
  - R, I, STORE: 4.
  - LOAD: 5.
- Each stall cycle adds exactly one cycle. The request stays high and unchanged through the stall, and is released the cycle after the stall-free cycle.
- Output timing:
  - State-dependent outputs are combinational from state plus class.
  - pc_sel in BTYPE also depends on branch_taken.
  - ir_we, the LOAD-to-WB transition and STORE retirement also depend on the stall inputs.
- pc_we is high for exactly one cycle per retired instruction; regwrite is high at most one cycle per instruction.
- retired updates on the edge ending the pc_we cycle, so it is visible one cycle later.

## Structure
- The shared package riscv_ctrl_pkg holds:
  - the state encoding (3 bits: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5);
  - the opcode constants;
  - the aluop, wb_sel and pc_sel encodings;
  - the class encoding.
- Sub-module op_class: combinational opcode-to-class map with a valid flag, reused for the registered class.
- The counter stays inline.

## Test plan
- ADD (0110011), no stalls, out of reset -> FETCH/DECODE/EXEC/WB in 4 cycles; regwrite=1 and wb_sel=00 only in WB; retired 0 -> 1.
- LOAD with icache_stall high for 2 cycles and dcache_stall high for 3 cycles -> 10 cycles total; icache_read high 3 cycles, dcache_read high 4 cycles; WB has wb_sel=01.
- BTYPE with branch_taken=1, then branch_taken=0 -> both finish in 3 cycles; pc_sel=01 then 00; regwrite never asserted.
- JALR -> EXEC shows regwrite=1, wb_sel=10, pc_we=1, pc_sel=10, aluop=11, alusrc=1, all in one cycle.
- Opcode 1111111 -> HALT after DECODE; illegal=1 sticky; no pc_we; rst=1 clears illegal and restarts FETCH.
- rst asserted during MEM of a STORE with dcache_stall=1 -> dcache_write drops the same cycle, no retirement; retired preloaded near all-ones wraps to 0 on the next retirement.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: states, opcodes,
// instruction classes and the datapath mux select codes.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_I     = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BR    = 3'd4,
        CLS_JAL   = 3'd5,
        CLS_JALR  = 3'd6
    } cls_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [1:0] ALUOP_R    = 2'b00;
    localparam logic [1:0] ALUOP_I    = 2'b01;
    localparam logic [1:0] ALUOP_ADDR = 2'b10;
    localparam logic [1:0] ALUOP_JUMP = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_op_class.sv
// Combinational opcode-to-class decoder; valid=0 flags an unsupported opcode.
module op_class
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       valid
);

    always_comb begin
        cls   = CLS_R;
        valid = 1'b1;
        case (opcode)
            OPC_R:     cls = CLS_R;
            OPC_I:     cls = CLS_I;
            OPC_LOAD:  cls = CLS_LOAD;
            OPC_STORE: cls = CLS_STORE;
            OPC_BR:    cls = CLS_BR;
            OPC_JAL:   cls = CLS_JAL;
            OPC_JALR:  cls = CLS_JALR;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB, handles cache
// stalls, halts on illegal opcodes and counts retired instructions.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             icache_read,
    output logic             ir_we,
    output logic             dcache_read,
    output logic             dcache_write,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic             regwrite,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_state_next;
    cls_t             r_cls;
    cls_t             w_dec_cls;
    logic             w_dec_valid;
    logic [CNT_W-1:0] r_retired;

    op_class u_op_class (
        .opcode (opcode),
        .cls    (w_dec_cls),
        .valid  (w_dec_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_cls     <= CLS_R;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            // Class is captured once; later opcode changes cannot disturb the instruction.
            if (r_state == ST_DECODE) begin
                r_cls <= w_dec_cls;
            end
            if (pc_we) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign retired = rst ? '0 : r_retired;

    always_comb begin
        w_state_next = r_state;
        icache_read  = 1'b0;
        ir_we        = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        alusrc       = 1'b0;
        aluop        = ALUOP_R;
        regwrite     = 1'b0;
        wb_sel       = WB_ALU;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        illegal      = 1'b0;
        // Reset silences every output in the same cycle, aborting any pending request.
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    icache_read = 1'b1;
                    if (!icache_stall) begin
                        ir_we        = 1'b1;
                        w_state_next = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    w_state_next = w_dec_valid ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    case (r_cls)
                        CLS_R: begin
                            aluop        = ALUOP_R;
                            w_state_next = ST_WB;
                        end
                        CLS_I: begin
                            aluop        = ALUOP_I;
                            alusrc       = 1'b1;
                            w_state_next = ST_WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            aluop        = ALUOP_ADDR;
                            alusrc       = 1'b1;
                            w_state_next = ST_MEM;
                        end
                        CLS_BR: begin
                            aluop        = ALUOP_ADDR;
                            pc_we        = 1'b1;
                            pc_sel       = branch_taken ? PC_TARGET : PC_PLUS4;
                            w_state_next = ST_FETCH;
                        end
                        CLS_JAL, CLS_JALR: begin
                            aluop        = ALUOP_JUMP;
                            alusrc       = (r_cls == CLS_JALR);
                            regwrite     = 1'b1;
                            wb_sel       = WB_PC4;
                            pc_we        = 1'b1;
                            pc_sel       = (r_cls == CLS_JALR) ? PC_JALR : PC_TARGET;
                            w_state_next = ST_FETCH;
                        end
                        default: w_state_next = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    aluop        = ALUOP_ADDR;
                    alusrc       = 1'b1;
                    dcache_read  = (r_cls == CLS_LOAD);
                    dcache_write = (r_cls != CLS_LOAD);
                    if (!dcache_stall) begin
                        if (r_cls == CLS_LOAD) begin
                            w_state_next = ST_WB;
                        end else begin
                            pc_we        = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    regwrite     = 1'b1;
                    pc_we        = 1'b1;
                    wb_sel       = (r_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                    w_state_next = ST_FETCH;
                end
                ST_HALT: begin
                    illegal = 1'b1;
                end
                default: w_state_next = ST_FETCH;
            endcase
        end
    end

endmodule
